// File: rtl/systolic_pe_db.sv
// systolic_pe_db: MAC processing element with double-buffered weights, weight- or output-stationary.
// Latency: 1 cycle from in_* to prop_*/out_*; OS results appear the cycle after acc_drain.
// Backpressure: none, valid-only flow; SYSTOLIC_PE_SAT_EN selects clamping adds and a sticky sat_flag.
module systolic_pe_db #(
    parameter int DATA_WIDTH = 8,
    parameter int ACC_WIDTH  = 24,
    parameter int SIGNED     = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  mode,
    input  logic                  in_valid,
    input  logic [DATA_WIDTH-1:0] in_data,
    input  logic [ACC_WIDTH-1:0]  in_psum,
    input  logic                  w_load,
    input  logic [DATA_WIDTH-1:0] w_data,
    input  logic                  w_swap,
    input  logic                  acc_drain,
    output logic [DATA_WIDTH-1:0] w_out,
    output logic                  prop_valid,
    output logic [DATA_WIDTH-1:0] prop_data,
    output logic                  out_valid,
    output logic [ACC_WIDTH-1:0]  out_psum,
    output logic                  sat_flag
);

    typedef enum logic {
        MODE_WS = 1'b0,
        MODE_OS = 1'b1
    } mode_t;

    mode_t mode_q;
    mode_t mode_d;
    logic  mode_change;

    logic [DATA_WIDTH-1:0] active_w;
    logic [DATA_WIDTH-1:0] shadow_w;
    logic [ACC_WIDTH-1:0]  acc;
    logic [ACC_WIDTH-1:0]  p;

`ifdef SYSTOLIC_PE_SAT_EN
    localparam int RW = ACC_WIDTH + 1;

    // Result bit ACC_WIDTH flags that the sum was clamped.
    function automatic logic [ACC_WIDTH:0] add_acc(input logic [ACC_WIDTH-1:0] a,
                                                   input logic [ACC_WIDTH-1:0] b);
        logic [ACC_WIDTH:0]   s;
        logic [ACC_WIDTH-1:0] smax;
        logic [ACC_WIDTH-1:0] smin;
        smax = {1'b0, {(ACC_WIDTH-1){1'b1}}};
        smin = {1'b1, {(ACC_WIDTH-1){1'b0}}};
        if (SIGNED != 0) begin
            s = {a[ACC_WIDTH-1], a} + {b[ACC_WIDTH-1], b};
            if (s[ACC_WIDTH] != s[ACC_WIDTH-1]) begin
                return {1'b1, (s[ACC_WIDTH] ? smin : smax)};
            end
            return {1'b0, s[ACC_WIDTH-1:0]};
        end else begin
            s = {1'b0, a} + {1'b0, b};
            if (s[ACC_WIDTH]) begin
                return {1'b1, {ACC_WIDTH{1'b1}}};
            end
            return {1'b0, s[ACC_WIDTH-1:0]};
        end
    endfunction
`else
    localparam int RW = ACC_WIDTH;

    function automatic logic [ACC_WIDTH-1:0] add_acc(input logic [ACC_WIDTH-1:0] a,
                                                     input logic [ACC_WIDTH-1:0] b);
        return a + b;
    endfunction
`endif

    logic [RW-1:0] ws_res;
    logic [RW-1:0] os_res;

    // Operands are widened before the multiply so the product lands directly in ACC_WIDTH.
    generate
        if (SIGNED != 0) begin : g_signed
            assign p = ACC_WIDTH'($signed(in_data)) * ACC_WIDTH'($signed(active_w));
        end else begin : g_unsigned
            assign p = ACC_WIDTH'(in_data) * ACC_WIDTH'(active_w);
        end
    endgenerate

    assign ws_res = add_acc(in_psum, p);
    assign os_res = add_acc(acc, (in_valid ? p : '0));

    always_ff @(posedge clk) begin
        if (rst) begin
            mode_q <= MODE_WS;
        end else begin
            mode_q <= mode_d;
        end
    end

    always_comb begin
        mode_d      = mode_q;
        mode_d      = mode ? MODE_OS : MODE_WS;
        mode_change = (mode_d != mode_q);
    end

    assign w_out = shadow_w;

    always_ff @(posedge clk) begin
        if (rst) begin
            active_w   <= '0;
            shadow_w   <= '0;
            acc        <= '0;
            out_psum   <= '0;
            out_valid  <= 1'b0;
            prop_data  <= '0;
            prop_valid <= 1'b0;
        end else begin
            prop_valid <= in_valid;
            if (in_valid) begin
                prop_data <= in_data;
            end
            // Swap reads the pre-edge shadow, so load+swap in one cycle moves the old weight.
            if (w_load) begin
                shadow_w <= w_data;
            end
            if (w_swap) begin
                active_w <= shadow_w;
            end
            out_valid <= 1'b0;
            if (mode_change) begin
                acc <= '0;
            end else if (mode_q == MODE_WS) begin
                if (in_valid) begin
                    out_psum  <= ws_res[ACC_WIDTH-1:0];
                    out_valid <= 1'b1;
                end
            end else begin
                if (acc_drain) begin
                    out_psum  <= os_res[ACC_WIDTH-1:0];
                    out_valid <= 1'b1;
                    acc       <= '0;
                end else if (in_valid) begin
                    acc <= os_res[ACC_WIDTH-1:0];
                end
            end
        end
    end

`ifdef SYSTOLIC_PE_SAT_EN
    logic clamp_hit;

    always_comb begin
        clamp_hit = 1'b0;
        if (!mode_change) begin
            if (mode_q == MODE_WS) begin
                clamp_hit = in_valid & ws_res[ACC_WIDTH];
            end else begin
                clamp_hit = (acc_drain | in_valid) & os_res[ACC_WIDTH];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sat_flag <= 1'b0;
        end else if (clamp_hit) begin
            sat_flag <= 1'b1;
        end
    end
`else
    assign sat_flag = 1'b0;
`endif

endmodule

// File: tb/tb_systolic_pe_db.sv
// tb_systolic_pe_db: directed vector table, corner-case sequences and a random run against an integer model.
// Expectations follow whether SYSTOLIC_PE_SAT_EN is defined for the build.
module tb_systolic_pe_db;
    localparam int DW   = 8;
    localparam int AW   = 16;
    localparam int MAXV = 32767;
    localparam int MINV = -32768;

    logic          clk = 1'b0;
    logic          rst;
    logic          mode;
    logic          in_valid;
    logic [DW-1:0] in_data;
    logic [AW-1:0] in_psum;
    logic          w_load;
    logic [DW-1:0] w_data;
    logic          w_swap;
    logic          acc_drain;
    logic [DW-1:0] w_out;
    logic          prop_valid;
    logic [DW-1:0] prop_data;
    logic          out_valid;
    logic [AW-1:0] out_psum;
    logic          sat_flag;

    int total = 0;
    int bad   = 0;

    systolic_pe_db #(.DATA_WIDTH(DW), .ACC_WIDTH(AW), .SIGNED(1)) dut (
        .clk(clk), .rst(rst), .mode(mode), .in_valid(in_valid), .in_data(in_data),
        .in_psum(in_psum), .w_load(w_load), .w_data(w_data), .w_swap(w_swap),
        .acc_drain(acc_drain), .w_out(w_out), .prop_valid(prop_valid),
        .prop_data(prop_data), .out_valid(out_valid), .out_psum(out_psum),
        .sat_flag(sat_flag)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_in();
        in_valid  = 1'b0;
        in_data   = '0;
        in_psum   = '0;
        w_load    = 1'b0;
        w_data    = '0;
        w_swap    = 1'b0;
        acc_drain = 1'b0;
    endtask

    function automatic int s8(input logic [DW-1:0] v);
        return int'($signed(v));
    endfunction

    function automatic int s16(input logic [AW-1:0] v);
        return int'($signed(v));
    endfunction

    // Reference arithmetic: plain integers, then clamp or wrap into the 16-bit signed range.
    function automatic int fit(input int v);
`ifdef SYSTOLIC_PE_SAT_EN
        if (v > MAXV) return MAXV;
        if (v < MINV) return MINV;
        return v;
`else
        return (((v - MINV) % 65536) + 65536) % 65536 + MINV;
`endif
    endfunction

    typedef struct {
        logic          md;
        logic          vld;
        logic [DW-1:0] dat;
        logic [AW-1:0] ps;
        logic          wl;
        logic [DW-1:0] wd;
        logic          sw;
        logic          dr;
        logic          e_ov;
        logic [AW-1:0] e_ps;
        logic [DW-1:0] e_pd;
        logic [DW-1:0] e_wo;
    } vec_t;

    vec_t tbl[16];

    int m_mode, m_sh, m_act, m_acc, m_ps, m_ov, m_pv, m_pd, m_sat;

    task automatic note(input int s);
`ifdef SYSTOLIC_PE_SAT_EN
        if (s > MAXV || s < MINV) m_sat = 1;
`else
        if (s > MAXV || s < MINV) m_sat = m_sat;
`endif
    endtask

    task automatic model_step();
        int p;
        int s;
        if (rst) begin
            m_mode = 0; m_sh = 0; m_act = 0; m_acc = 0;
            m_ps = 0; m_ov = 0; m_pv = 0; m_pd = 0; m_sat = 0;
        end else begin
            p = s8(in_data) * m_act;
            m_pv = int'(in_valid);
            if (in_valid) m_pd = s8(in_data);
            m_ov = 0;
            if (int'(mode) != m_mode) begin
                m_acc = 0;
            end else if (mode == 1'b0) begin
                if (in_valid) begin
                    s = s16(in_psum) + p;
                    note(s);
                    m_ps = fit(s);
                    m_ov = 1;
                end
            end else if (acc_drain) begin
                s = m_acc + (in_valid ? p : 0);
                note(s);
                m_ps = fit(s);
                m_ov = 1;
                m_acc = 0;
            end else if (in_valid) begin
                s = m_acc + p;
                note(s);
                m_acc = fit(s);
            end
            m_mode = int'(mode);
            if (w_swap) m_act = m_sh;
            if (w_load) m_sh = s8(w_data);
        end
    endtask

    initial begin
        int sat_exp;
        sat_exp = 0;
`ifdef SYSTOLIC_PE_SAT_EN
        sat_exp = 1;
`endif
        //          md    vld   dat    ps        wl    wd     sw    dr  | ov    psum        pd     w_out
        tbl[0]  = '{1'b0, 1'b0, 8'd0, 16'd0,   1'b1, 8'd3,  1'b0, 1'b0, 1'b0, 16'd0,      8'd0, 8'd3};
        tbl[1]  = '{1'b0, 1'b0, 8'd0, 16'd0,   1'b0, 8'd0,  1'b1, 1'b0, 1'b0, 16'd0,      8'd0, 8'd3};
        tbl[2]  = '{1'b0, 1'b1, 8'd5, 16'd10,  1'b0, 8'd0,  1'b0, 1'b0, 1'b1, 16'd25,     8'd5, 8'd3};
        tbl[3]  = '{1'b0, 1'b0, 8'd0, 16'd0,   1'b0, 8'd0,  1'b0, 1'b0, 1'b0, 16'd25,     8'd5, 8'd3};
        tbl[4]  = '{1'b0, 1'b0, 8'd0, 16'd0,   1'b1, 8'd2,  1'b0, 1'b0, 1'b0, 16'd25,     8'd5, 8'd2};
        tbl[5]  = '{1'b0, 1'b0, 8'd0, 16'd0,   1'b0, 8'd0,  1'b1, 1'b0, 1'b0, 16'd25,     8'd5, 8'd2};
        tbl[6]  = '{1'b0, 1'b1, 8'd4, 16'd100, 1'b1, 8'd7,  1'b1, 1'b0, 1'b1, 16'd108,    8'd4, 8'd7};
        tbl[7]  = '{1'b0, 1'b0, 8'd0, 16'd0,   1'b0, 8'd0,  1'b1, 1'b0, 1'b0, 16'd108,    8'd4, 8'd7};
        tbl[8]  = '{1'b0, 1'b1, 8'd3, 16'd0,   1'b0, 8'd0,  1'b0, 1'b0, 1'b1, 16'd21,     8'd3, 8'd7};
        tbl[9]  = '{1'b1, 1'b0, 8'd0, 16'd0,   1'b1, 8'hFE, 1'b0, 1'b0, 1'b0, 16'd21,     8'd3, 8'hFE};
        tbl[10] = '{1'b1, 1'b0, 8'd0, 16'd0,   1'b0, 8'd0,  1'b1, 1'b0, 1'b0, 16'd21,     8'd3, 8'hFE};
        tbl[11] = '{1'b1, 1'b1, 8'd1, 16'd999, 1'b0, 8'd0,  1'b0, 1'b0, 1'b0, 16'd21,     8'd1, 8'hFE};
        tbl[12] = '{1'b1, 1'b1, 8'd2, 16'd999, 1'b0, 8'd0,  1'b0, 1'b0, 1'b0, 16'd21,     8'd2, 8'hFE};
        tbl[13] = '{1'b1, 1'b1, 8'd3, 16'd999, 1'b0, 8'd0,  1'b0, 1'b0, 1'b0, 16'd21,     8'd3, 8'hFE};
        tbl[14] = '{1'b1, 1'b1, 8'd4, 16'd999, 1'b0, 8'd0,  1'b0, 1'b1, 1'b1, 16'hFFEC,   8'd4, 8'hFE};
        tbl[15] = '{1'b1, 1'b0, 8'd0, 16'd0,   1'b0, 8'd0,  1'b0, 1'b1, 1'b1, 16'd0,      8'd4, 8'hFE};

        rst = 1'b1;
        mode = 1'b0;
        clear_in();
        tick();
        tick();
        check("reset out_valid", int'(out_valid), 0);
        check("reset out_psum", s16(out_psum), 0);
        check("reset prop_valid", int'(prop_valid), 0);
        check("reset prop_data", s8(prop_data), 0);
        check("reset w_out", s8(w_out), 0);
        check("reset sat_flag", int'(sat_flag), 0);
        rst = 1'b0;

        for (int i = 0; i < 16; i++) begin
            mode = tbl[i].md; in_valid = tbl[i].vld; in_data = tbl[i].dat; in_psum = tbl[i].ps;
            w_load = tbl[i].wl; w_data = tbl[i].wd; w_swap = tbl[i].sw; acc_drain = tbl[i].dr;
            tick();
            check($sformatf("tbl%0d out_valid", i), int'(out_valid), int'(tbl[i].e_ov));
            check($sformatf("tbl%0d out_psum", i), s16(out_psum), s16(tbl[i].e_ps));
            check($sformatf("tbl%0d prop_data", i), s8(prop_data), s8(tbl[i].e_pd));
            check($sformatf("tbl%0d w_out", i), s8(w_out), s8(tbl[i].e_wo));
        end

        // OS -> WS with acc=9: switch cycle drops its input, next WS input is normal.
        clear_in(); mode = 1'b1; w_load = 1'b1; w_data = 8'd3; tick();
        clear_in(); w_swap = 1'b1; tick();
        clear_in(); in_valid = 1'b1; in_data = 8'd3; tick();
        check("os acc9 no out", int'(out_valid), 0);
        clear_in(); mode = 1'b0; in_valid = 1'b1; in_data = 8'd1; in_psum = 16'd5; tick();
        check("switch out_valid", int'(out_valid), 0);
        check("switch out_psum hold", s16(out_psum), 0);
        tick();
        check("after switch out_valid", int'(out_valid), 1);
        check("after switch out_psum", s16(out_psum), 8);

        // Saturation / wrap at the 16-bit boundary.
        clear_in(); w_load = 1'b1; w_data = 8'd1; tick();
        clear_in(); w_swap = 1'b1; tick();
        clear_in(); in_valid = 1'b1; in_data = 8'd127; in_psum = 16'd32760; tick();
        check("sat pos out_valid", int'(out_valid), 1);
        check("sat pos out_psum", s16(out_psum), (sat_exp != 0) ? 32767 : -32649);
        check("sat pos flag", int'(sat_flag), sat_exp);
        in_data = 8'd1; in_psum = 16'd0; tick();
        check("sat sticky psum", s16(out_psum), 1);
        check("sat sticky flag", int'(sat_flag), sat_exp);
        in_data = 8'h80; in_psum = 16'h8000; tick();
        check("sat neg out_psum", s16(out_psum), (sat_exp != 0) ? -32768 : 32640);

        // Reset in the middle of an OS accumulation.
        clear_in(); mode = 1'b1; tick();
        clear_in(); w_load = 1'b1; w_data = 8'd5; tick();
        clear_in(); w_swap = 1'b1; tick();
        clear_in(); in_valid = 1'b1; in_data = 8'd10; tick();
        check("acc50 no out", int'(out_valid), 0);
        clear_in(); rst = 1'b1; tick(); rst = 1'b0;
        check("midrst out_valid", int'(out_valid), 0);
        check("midrst out_psum", s16(out_psum), 0);
        check("midrst sat_flag", int'(sat_flag), 0);
        check("midrst w_out", s8(w_out), 0);
        tick();
        check("post rst switch out_valid", int'(out_valid), 0);
        acc_drain = 1'b1; tick();
        check("post rst drain out_valid", int'(out_valid), 1);
        check("post rst drain out_psum", s16(out_psum), 0);

        // Random run against the integer model.
        clear_in();
        rst = 1'b1;
        model_step();
        tick();
        for (int c = 0; c < 400; c++) begin
            rst       = ($urandom_range(0, 49) == 0);
            if ($urandom_range(0, 15) == 0) mode = ~mode;
            in_valid  = ($urandom_range(0, 3) != 0);
            in_data   = DW'($urandom);
            in_psum   = AW'($urandom);
            w_load    = ($urandom_range(0, 5) == 0);
            w_data    = DW'($urandom);
            w_swap    = ($urandom_range(0, 7) == 0);
            acc_drain = ($urandom_range(0, 5) == 0);
            model_step();
            tick();
            check($sformatf("rnd%0d out_valid", c), int'(out_valid), m_ov);
            check($sformatf("rnd%0d out_psum", c), s16(out_psum), m_ps);
            check($sformatf("rnd%0d prop_valid", c), int'(prop_valid), m_pv);
            check($sformatf("rnd%0d prop_data", c), s8(prop_data), m_pd);
            check($sformatf("rnd%0d w_out", c), s8(w_out), m_sh);
            check($sformatf("rnd%0d sat_flag", c), int'(sat_flag), m_sat);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
